// File: rtl/rest_div_n_if.sv
// Start/valid handshake bundle for the rest_div_n restoring divider.
// The master drives the operands and start; the slave returns the result.
interface rest_div_n_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             div_zero;

    modport master (
        output start, signed_op, X, Y,
        input  busy, valid, quot, rem, div_zero
    );

    modport slave (
        input  start, signed_op, X, Y,
        output busy, valid, quot, rem, div_zero
    );
endinterface

// File: rtl/rest_div_n.sv
// Multi-cycle restoring divider: one quotient bit per cycle, optional
// two's-complement mode, and a one-cycle fast path for a zero divisor.
module rest_div_n #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input logic         clk,
    input logic         rst,
    rest_div_n_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic             armed;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] xr;        // dividend magnitude, shifted out as quotient bits shift in
    logic [WIDTH-1:0] dm;
    logic [WIDTH-1:0] pr;
    logic             qneg, rneg, zf;
    logic             accept, step, finish;

    logic             sgn, x_neg, y_neg, y_zero;
    logic [WIDTH-1:0] x_mag, y_mag;
    logic [WIDTH:0]   pr_sh;
    logic             trial_neg;
    logic [WIDTH-1:0] trial_diff;

    assign sgn    = SIGNED_EN & bus.signed_op;
    assign x_neg  = sgn & bus.X[WIDTH-1];
    assign y_neg  = sgn & bus.Y[WIDTH-1];
    assign x_mag  = x_neg ? ('0 - bus.X) : bus.X;
    assign y_mag  = y_neg ? ('0 - bus.Y) : bus.Y;
    assign y_zero = (bus.Y == '0);

    // pr < dm always holds, so a successful trial fits back into WIDTH bits.
    assign pr_sh      = {pr, xr[WIDTH-1]};
    assign trial_neg  = pr_sh < {1'b0, dm};
    assign trial_diff = pr_sh[WIDTH-1:0] - dm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: if (bus.start && armed) begin
                accept  = 1'b1;
                state_d = y_zero ? DONE : CALC;
            end
            CALC: begin
                step = 1'b1;
                if (cnt == LAST) state_d = DONE;
            end
            DONE: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed        <= 1'b0;
            cnt          <= '0;
            xr           <= '0;
            dm           <= '0;
            pr           <= '0;
            qneg         <= 1'b0;
            rneg         <= 1'b0;
            zf           <= 1'b0;
            bus.busy     <= 1'b0;
            bus.valid    <= 1'b0;
            bus.quot     <= '0;
            bus.rem      <= '0;
            bus.div_zero <= 1'b0;
        end else begin
            armed     <= 1'b1;
            bus.valid <= 1'b0;
            if (accept) begin
                // A zero divisor keeps the raw dividend so it can be returned as rem.
                xr       <= y_zero ? bus.X : x_mag;
                dm       <= y_mag;
                pr       <= '0;
                cnt      <= '0;
                qneg     <= sgn & (bus.X[WIDTH-1] ^ bus.Y[WIDTH-1]);
                rneg     <= x_neg;
                zf       <= y_zero;
                bus.busy <= 1'b1;
            end
            if (step) begin
                xr  <= {xr[WIDTH-2:0], ~trial_neg};
                pr  <= trial_neg ? pr_sh[WIDTH-1:0] : trial_diff;
                cnt <= cnt + CW'(1);
            end
            if (finish) begin
                bus.valid    <= 1'b1;
                bus.busy     <= 1'b0;
                bus.div_zero <= zf;
                if (zf) begin
                    bus.quot <= '1;
                    bus.rem  <= xr;
                end else begin
                    bus.quot <= qneg ? ('0 - xr) : xr;
                    bus.rem  <= rneg ? ('0 - pr) : pr;
                end
            end
        end
    end
endmodule

// File: tb/tb_rest_div_n.sv
// Directed bench for rest_div_n: a 4-bit and an 8-bit instance checked
// against hand-computed quotients, remainders, latencies and flags.
module tb_rest_div_n;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rest_div_n_if #(.WIDTH(4)) bus4 ();
    rest_div_n_if #(.WIDTH(8)) bus8 ();

    rest_div_n #(.WIDTH(4), .SIGNED_EN(1'b1)) u_div4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    rest_div_n #(.WIDTH(8), .SIGNED_EN(1'b1)) u_div8 (.clk(clk), .rst(rst), .bus(bus8.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic get_valid(input bit w8);
        return w8 ? bus8.valid : bus4.valid;
    endfunction
    function automatic logic get_busy(input bit w8);
        return w8 ? bus8.busy : bus4.busy;
    endfunction
    function automatic logic get_dz(input bit w8);
        return w8 ? bus8.div_zero : bus4.div_zero;
    endfunction
    function automatic logic [7:0] get_quot(input bit w8);
        return w8 ? bus8.quot : {4'b0, bus4.quot};
    endfunction
    function automatic logic [7:0] get_rem(input bit w8);
        return w8 ? bus8.rem : {4'b0, bus4.rem};
    endfunction

    // Present a one-cycle start pulse; returns at the negedge after the accepting edge.
    task automatic launch(input bit w8, input logic sop, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        if (w8) begin
            bus8.start = 1'b1; bus8.signed_op = sop; bus8.X = x; bus8.Y = y;
        end else begin
            bus4.start = 1'b1; bus4.signed_op = sop; bus4.X = x[3:0]; bus4.Y = y[3:0];
        end
        @(negedge clk);
        bus8.start = 1'b0;
        bus4.start = 1'b0;
    endtask

    // Called one negedge after the accepting edge; repulse_at >= 0 re-pulses start on bus8 mid-run.
    task automatic wait_result(input bit w8, input string tag, input int exp_lat,
                               input logic [7:0] eq, input logic [7:0] er, input logic ez,
                               input int repulse_at);
        int lat = 0;
        bit busy_ok = 1'b1;
        while (!get_valid(w8) && lat < 40) begin
            if (!get_busy(w8)) busy_ok = 1'b0;
            if (lat == repulse_at) begin
                bus8.start = 1'b1; bus8.X = 8'd50; bus8.Y = 8'd5;
            end else begin
                bus8.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus8.start = 1'b0;
        if (lat >= 40) begin
            check({tag, "_timeout"}, 32'd1, 32'd0);
            return;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_held"}, busy_ok, 1'b1);
        check({tag, "_busy_fall"}, get_busy(w8), 1'b0);
        check({tag, "_quot"}, get_quot(w8), eq);
        check({tag, "_rem"}, get_rem(w8), er);
        check({tag, "_div_zero"}, get_dz(w8), ez);
        @(negedge clk);
        check({tag, "_valid_pulse"}, get_valid(w8), 1'b0);
        check({tag, "_quot_hold"}, get_quot(w8), eq);
    endtask

    initial begin
        bit no_valid;
        bus4.start = 1'b0; bus4.signed_op = 1'b0; bus4.X = '0; bus4.Y = '0;
        bus8.start = 1'b0; bus8.signed_op = 1'b0; bus8.X = '0; bus8.Y = '0;

        repeat (2) @(negedge clk);
        check("rst_outs4", {bus4.busy, bus4.valid, bus4.div_zero, bus4.quot, bus4.rem}, '0);
        check("rst_outs8", {bus8.busy, bus8.valid, bus8.div_zero, bus8.quot, bus8.rem}, '0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        launch(1'b0, 1'b0, 8'd15, 8'd8);  wait_result(1'b0, "u4_15_8",  5, 8'h1, 8'h7, 1'b0, -1);
        launch(1'b0, 1'b0, 8'd10, 8'd2);  wait_result(1'b0, "u4_10_2",  5, 8'h5, 8'h0, 1'b0, -1);
        launch(1'b0, 1'b0, 8'd9,  8'd0);  wait_result(1'b0, "u4_9_0",   1, 8'hF, 8'h9, 1'b1, -1);
        launch(1'b0, 1'b0, 8'd7,  8'd3);  wait_result(1'b0, "u4_7_3",   5, 8'h2, 8'h1, 1'b0, -1);

        launch(1'b1, 1'b1, 8'hF9, 8'h02); wait_result(1'b1, "s8_m7_2",  9, 8'hFD, 8'hFF, 1'b0, -1);
        launch(1'b1, 1'b1, 8'h07, 8'hFE); wait_result(1'b1, "s8_7_m2",  9, 8'hFD, 8'h01, 1'b0, -1);
        launch(1'b1, 1'b1, 8'h80, 8'hFF); wait_result(1'b1, "s8_min_m1", 9, 8'h80, 8'h00, 1'b0, -1);
        launch(1'b1, 1'b0, 8'h80, 8'hFF); wait_result(1'b1, "u8_80_ff", 9, 8'h00, 8'h80, 1'b0, -1);
        launch(1'b1, 1'b1, 8'h9C, 8'h07); wait_result(1'b1, "s8_m100_7", 9, 8'hF2, 8'hFE, 1'b0, -1);
        launch(1'b1, 1'b1, 8'hF9, 8'h00); wait_result(1'b1, "s8_dz",    1, 8'hFF, 8'hF9, 1'b1, -1);

        launch(1'b1, 1'b0, 8'd100, 8'd7); wait_result(1'b1, "u8_repulse", 9, 8'd14, 8'd2, 1'b0, 2);
        no_valid = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (bus8.valid) no_valid = 1'b0;
        end
        check("repulse_single_valid", no_valid, 1'b1);

        // Abort a divide after its third edge; the result must never appear.
        launch(1'b1, 1'b0, 8'd100, 8'd7);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("abort_outs", {bus8.busy, bus8.valid, bus8.div_zero, bus8.quot, bus8.rem}, '0);
        no_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus8.valid) no_valid = 1'b0;
        end
        check("abort_no_valid", no_valid, 1'b1);
        bus8.start = 1'b1; bus8.signed_op = 1'b0; bus8.X = 8'd200; bus8.Y = 8'd10;
        rst = 1'b1;
        @(negedge clk);
        check("release_first_edge_idle", bus8.busy, 1'b0);
        @(negedge clk);
        bus8.start = 1'b0;
        check("release_second_edge_accept", bus8.busy, 1'b1);
        wait_result(1'b1, "u8_200_10", 9, 8'd20, 8'd0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
